// File: rtl/l1_cache_control.sv
// Sequencing FSM for the 2-way, 8-set write-back L1: hit service, dirty-victim
// writeback and line fill, plus saturating hit/miss event counters.
module l1_cache_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic        hit0,
    input  logic        hit1,
    input  logic        v_out0,
    input  logic        v_out1,
    input  logic        d_out0,
    input  logic        d_out1,
    input  logic        lru_out,
    output logic        load_lru,
    output logic        lru_in,
    output logic        l2wdata_sel,
    output logic        load_d0,
    output logic        load_v0,
    output logic        load_TD0,
    output logic        d_in0,
    output logic        v_in0,
    output logic        load_d1,
    output logic        load_v1,
    output logic        load_TD1,
    output logic        d_in1,
    output logic        v_in1,
    output logic [1:0]  l2addr_sel,
    output logic        l2_read,
    output logic        l2_write,
    input  logic        l2_resp,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WRITEBACK = 2'b01,
        FILL      = 2'b10
    } state_t;

    state_t      state_r, state_s;
    logic        victim_r, victim_s;
    logic [15:0] hit_count_r, miss_count_r;

    logic        req_s, hit_s, victim_dirty_s, hit_evt_s, miss_evt_s;
    logic        mem_resp_s, load_lru_s, lru_in_s, l2wdata_sel_s;
    logic        load_d0_s, load_v0_s, load_TD0_s, d_in0_s, v_in0_s;
    logic        load_d1_s, load_v1_s, load_TD1_s, d_in1_s, v_in1_s;
    logic [1:0]  l2addr_sel_s;
    logic        l2_read_s, l2_write_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            sat_inc = val;
        end else begin
            sat_inc = val + 16'd1;
        end
    endfunction

    assign req_s          = mem_read | mem_write;
    assign hit_s          = hit0 | hit1;
    assign victim_dirty_s = lru_out ? (v_out1 & d_out1) : (v_out0 & d_out0);
    assign hit_evt_s      = (state_r == IDLE) & req_s & hit_s;
    assign miss_evt_s     = (state_r == IDLE) & req_s & ~hit_s;

    // Next-state and Mealy control decode
    always_comb begin
        state_s       = state_r;
        victim_s      = victim_r;
        mem_resp_s    = 1'b0;
        load_lru_s    = 1'b0;
        lru_in_s      = 1'b0;
        l2wdata_sel_s = 1'b0;
        load_d0_s     = 1'b0;
        load_v0_s     = 1'b0;
        load_TD0_s    = 1'b0;
        d_in0_s       = 1'b0;
        v_in0_s       = 1'b0;
        load_d1_s     = 1'b0;
        load_v1_s     = 1'b0;
        load_TD1_s    = 1'b0;
        d_in1_s       = 1'b0;
        v_in1_s       = 1'b0;
        l2addr_sel_s  = 2'b00;
        l2_read_s     = 1'b0;
        l2_write_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s && hit_s) begin
                    mem_resp_s    = 1'b1;
                    l2wdata_sel_s = hit1;
                    load_lru_s    = 1'b1;
                    lru_in_s      = ~hit1;
                    // a simultaneous read+write is served as a write
                    if (mem_write) begin
                        load_TD0_s = ~hit1;
                        load_d0_s  = ~hit1;
                        d_in0_s    = ~hit1;
                        load_TD1_s = hit1;
                        load_d1_s  = hit1;
                        d_in1_s    = hit1;
                    end else begin
                        load_TD0_s = 1'b0;
                    end
                end else if (req_s) begin
                    victim_s = lru_out;
                    state_s  = victim_dirty_s ? WRITEBACK : FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITEBACK: begin
                l2_write_s    = 1'b1;
                l2wdata_sel_s = victim_r;
                l2addr_sel_s  = victim_r ? 2'b10 : 2'b01;
                if (l2_resp) begin
                    state_s = FILL;
                end else begin
                    state_s = WRITEBACK;
                end
            end
            FILL: begin
                l2_read_s = 1'b1;
                // fill installs a clean, valid line; the re-evaluated hit sets dirty on writes
                if (l2_resp) begin
                    load_TD0_s = ~victim_r;
                    load_v0_s  = ~victim_r;
                    v_in0_s    = ~victim_r;
                    load_d0_s  = ~victim_r;
                    load_TD1_s = victim_r;
                    load_v1_s  = victim_r;
                    v_in1_s    = victim_r;
                    load_d1_s  = victim_r;
                    state_s    = IDLE;
                end else begin
                    state_s = FILL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, victim way and event counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            victim_r     <= 1'b0;
            hit_count_r  <= 16'h0000;
            miss_count_r <= 16'h0000;
        end else begin
            state_r  <= state_s;
            victim_r <= victim_s;
            if (hit_evt_s) begin
                hit_count_r <= sat_inc(hit_count_r);
            end else begin
                hit_count_r <= hit_count_r;
            end
            if (miss_evt_s) begin
                miss_count_r <= sat_inc(miss_count_r);
            end else begin
                miss_count_r <= miss_count_r;
            end
        end
    end

    // Controls are forced low for as long as reset is held
    assign mem_resp    = rst_n & mem_resp_s;
    assign load_lru    = rst_n & load_lru_s;
    assign lru_in      = rst_n & lru_in_s;
    assign l2wdata_sel = rst_n & l2wdata_sel_s;
    assign load_d0     = rst_n & load_d0_s;
    assign load_v0     = rst_n & load_v0_s;
    assign load_TD0    = rst_n & load_TD0_s;
    assign d_in0       = rst_n & d_in0_s;
    assign v_in0       = rst_n & v_in0_s;
    assign load_d1     = rst_n & load_d1_s;
    assign load_v1     = rst_n & load_v1_s;
    assign load_TD1    = rst_n & load_TD1_s;
    assign d_in1       = rst_n & d_in1_s;
    assign v_in1       = rst_n & v_in1_s;
    assign l2addr_sel  = rst_n ? l2addr_sel_s : 2'b00;
    assign l2_read     = rst_n & l2_read_s;
    assign l2_write    = rst_n & l2_write_s;
    assign hit_count   = hit_count_r;
    assign miss_count  = miss_count_r;

endmodule

// File: tb/tb_l1_cache_control.sv
// Bench for l1_cache_control: a small tag/valid/dirty/LRU array and an L2 responder
// surround the DUT; a queue-based transaction model predicts every control cycle.
module tb_l1_cache_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, mem_read, mem_write, mem_resp;
    logic hit0, hit1, v_out0, v_out1, d_out0, d_out1, lru_out;
    logic load_lru, lru_in, l2wdata_sel;
    logic load_d0, load_v0, load_TD0, d_in0, v_in0;
    logic load_d1, load_v1, load_TD1, d_in1, v_in1;
    logic [1:0] l2addr_sel;
    logic l2_read, l2_write, l2_resp;
    logic [15:0] hit_count, miss_count;

    l1_cache_control dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .hit0(hit0), .hit1(hit1), .v_out0(v_out0), .v_out1(v_out1),
        .d_out0(d_out0), .d_out1(d_out1), .lru_out(lru_out), .load_lru(load_lru),
        .lru_in(lru_in), .l2wdata_sel(l2wdata_sel), .load_d0(load_d0), .load_v0(load_v0),
        .load_TD0(load_TD0), .d_in0(d_in0), .v_in0(v_in0), .load_d1(load_d1),
        .load_v1(load_v1), .load_TD1(load_TD1), .d_in1(d_in1), .v_in1(v_in1),
        .l2addr_sel(l2addr_sel), .l2_read(l2_read), .l2_write(l2_write), .l2_resp(l2_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // datapath arrays seen by the DUT, written only through the DUT's load controls
    logic       vld [0:1][0:7];
    logic       drt [0:1][0:7];
    logic [3:0] tg  [0:1][0:7];
    logic       lru [0:7];
    logic [2:0] cur_set;
    logic [3:0] cur_tag;
    logic [17:0] cap;

    // transaction model: pending L2 phases (1 = writeback, 2 = fill)
    int   ph[$];
    logic m_victim;
    int   m_hits, m_miss;

    int   l2_cnt, l2_lat;
    bit   spurious_en;
    int   n_tests, n_fail;

    function automatic logic [17:0] dut_ctrl();
        dut_ctrl = {mem_resp, load_lru, lru_in, l2wdata_sel,
                    load_d0, load_v0, load_TD0, d_in0, v_in0,
                    load_d1, load_v1, load_TD1, d_in1, v_in1,
                    l2addr_sel, l2_read, l2_write};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph.delete();
        m_victim = 1'b0;
        m_hits = 0;
        m_miss = 0;
        cap = '0;
        l2_cnt = 0;
    endtask

    task automatic commit();
        if (cap[11]) tg[0][cur_set] = cur_tag;
        if (cap[12]) vld[0][cur_set] = cap[9];
        if (cap[13]) drt[0][cur_set] = cap[10];
        if (cap[6])  tg[1][cur_set] = cur_tag;
        if (cap[7])  vld[1][cur_set] = cap[4];
        if (cap[8])  drt[1][cur_set] = cap[5];
        if (cap[16]) lru[cur_set] = cap[15];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) commit();
    endtask

    task automatic settle_check();
        logic mr, ll, li, ws, rd2, wr2, h, req;
        logic [1:0] as, ltd, lv, vi, ld, di;
        logic [17:0] exp_v, act_v;
        hit0    = vld[0][cur_set] && (tg[0][cur_set] == cur_tag);
        hit1    = vld[1][cur_set] && (tg[1][cur_set] == cur_tag);
        v_out0  = vld[0][cur_set];
        v_out1  = vld[1][cur_set];
        d_out0  = drt[0][cur_set];
        d_out1  = drt[1][cur_set];
        lru_out = lru[cur_set];
        #1;
        if (l2_read || l2_write) begin
            l2_cnt++;
            l2_resp = (l2_cnt >= l2_lat);
            if (l2_resp) begin
                l2_cnt = 0;
                if (spurious_en) l2_lat = $urandom_range(1, 4);
            end
        end else begin
            l2_cnt = 0;
            l2_resp = spurious_en && ($urandom_range(0, 3) == 0);
        end
        #3;
        {mr, ll, li, ws, rd2, wr2} = 6'b0;
        {as, ltd, lv, vi, ld, di} = 12'b0;
        req = mem_read || mem_write;
        if (rst_n) begin
            if (ph.size() == 0) begin
                if (req && (hit0 || hit1)) begin
                    h = hit1;
                    mr = 1'b1; ws = h; ll = 1'b1; li = !h;
                    if (mem_write) begin ltd[h] = 1'b1; ld[h] = 1'b1; di[h] = 1'b1; end
                end
            end else if (ph[0] == 1) begin
                wr2 = 1'b1; ws = m_victim; as = m_victim ? 2'b10 : 2'b01;
            end else begin
                rd2 = 1'b1;
                if (l2_resp) begin
                    ltd[m_victim] = 1'b1; lv[m_victim] = 1'b1;
                    vi[m_victim] = 1'b1; ld[m_victim] = 1'b1;
                end
            end
        end
        exp_v = {mr, ll, li, ws, ld[0], lv[0], ltd[0], di[0], vi[0],
                 ld[1], lv[1], ltd[1], di[1], vi[1], as, rd2, wr2};
        act_v = dut_ctrl();
        chk("ctrl", int'(act_v), int'(exp_v));
        chk("hit_count", int'(hit_count), m_hits);
        chk("miss_count", int'(miss_count), m_miss);
        cap = act_v;
        if (rst_n) begin
            if (ph.size() == 0) begin
                if (req && (hit0 || hit1)) begin
                    if (m_hits < 65535) m_hits++;
                end else if (req) begin
                    m_victim = lru_out;
                    if (m_miss < 65535) m_miss++;
                    if (lru_out ? (v_out1 && d_out1) : (v_out0 && d_out0)) ph.push_back(1);
                    ph.push_back(2);
                end
            end else if (l2_resp) begin
                void'(ph.pop_front());
            end
        end
    endtask

    task automatic step(input logic rd, input logic wr, input logic [2:0] s, input logic [3:0] t);
        tick();
        mem_read = rd;
        mem_write = wr;
        cur_set = s;
        cur_tag = t;
        settle_check();
    endtask

    initial begin
        logic req_on, rdv, wrv;
        logic [2:0] rs;
        logic [3:0] rt;
        int waited;
        n_tests = 0; n_fail = 0;
        spurious_en = 1'b0; l2_lat = 3;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; l2_resp = 1'b0;
        hit0 = 1'b0; hit1 = 1'b0; v_out0 = 1'b0; v_out1 = 1'b0;
        d_out0 = 1'b0; d_out1 = 1'b0; lru_out = 1'b0;
        cur_set = 3'd0; cur_tag = 4'd0;
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 8; s++) begin
                vld[w][s] = 1'b0; drt[w][s] = 1'b0; tg[w][s] = 4'd0; lru[s] = 1'b0;
            end
        end
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_ctrl", int'(dut_ctrl()), 0);
        chk("reset_hits", int'(hit_count), 0);
        chk("reset_miss", int'(miss_count), 0);
        rst_n = 1'b1;

        // read hit way 1
        vld[1][3] = 1'b1; tg[1][3] = 4'd5;
        step(1'b1, 1'b0, 3'd3, 4'd5);
        chk("rh_mem_resp", int'(cap[17]), 1);
        chk("rh_wsel", int'(cap[14]), 1);
        chk("rh_load_lru", int'(cap[16]), 1);
        chk("rh_lru_in", int'(cap[15]), 0);
        chk("rh_load_TD1", int'(cap[6]), 0);
        step(1'b0, 1'b0, 3'd3, 4'd5);
        chk("rh_hit_count", int'(hit_count), 1);

        // write hit way 0
        vld[0][2] = 1'b1; tg[0][2] = 4'd7;
        step(1'b0, 1'b1, 3'd2, 4'd7);
        chk("wh_load_TD0", int'(cap[11]), 1);
        chk("wh_load_d0", int'(cap[13]), 1);
        chk("wh_d_in0", int'(cap[10]), 1);
        chk("wh_lru_in", int'(cap[15]), 1);
        chk("wh_mem_resp", int'(cap[17]), 1);

        // clean read miss, fill takes 3 cycles
        l2_lat = 3;
        step(1'b1, 1'b0, 3'd4, 4'd9);
        chk("cm_no_resp", int'(cap[17]), 0);
        chk("cm_no_l2rd", int'(cap[1]), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 3'd4, 4'd9);
            chk("cm_l2_read", int'(cap[1]), 1);
            chk("cm_addr_sel", int'(cap[3:2]), 0);
        end
        chk("cm_load_TD0", int'(cap[11]), 1);
        chk("cm_load_v0", int'(cap[12]), 1);
        chk("cm_v_in0", int'(cap[9]), 1);
        chk("cm_d_in0", int'(cap[10]), 0);
        step(1'b1, 1'b0, 3'd4, 4'd9);
        chk("cm_mem_resp", int'(cap[17]), 1);
        step(1'b0, 1'b0, 3'd4, 4'd9);
        chk("cm_miss_count", int'(miss_count), 1);
        chk("cm_hit_count", int'(hit_count), 3);

        // dirty write miss on way 1
        l2_lat = 2;
        vld[1][5] = 1'b1; drt[1][5] = 1'b1; tg[1][5] = 4'd2; lru[5] = 1'b1;
        vld[0][5] = 1'b1; tg[0][5] = 4'd1;
        step(1'b0, 1'b1, 3'd5, 4'd3);
        step(1'b0, 1'b1, 3'd5, 4'd3);
        chk("dm_l2_write", int'(cap[0]), 1);
        chk("dm_addr_sel", int'(cap[3:2]), 2);
        chk("dm_wsel", int'(cap[14]), 1);
        repeat (3) step(1'b0, 1'b1, 3'd5, 4'd3);
        chk("dm_fill_v1", int'(cap[7]), 1);
        step(1'b0, 1'b1, 3'd5, 4'd3);
        chk("dm_mem_resp", int'(cap[17]), 1);
        chk("dm_load_d1", int'(cap[8]), 1);
        chk("dm_d_in1", int'(cap[5]), 1);
        step(1'b0, 1'b0, 3'd5, 4'd3);

        // reset asserted mid-fill
        l2_lat = 4;
        step(1'b1, 1'b0, 3'd6, 4'd4);
        step(1'b1, 1'b0, 3'd6, 4'd4);
        chk("rf_in_fill", int'(cap[1]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rf_ctrl_zero", int'(dut_ctrl()), 0);
        chk("rf_hits_zero", int'(hit_count), 0);
        chk("rf_miss_zero", int'(miss_count), 0);
        model_reset();
        mem_read = 1'b0;
        repeat (2) step(1'b0, 1'b0, 3'd6, 4'd4);
        #2 rst_n = 1'b1;
        step(1'b0, 1'b0, 3'd6, 4'd4);
        chk("rf_l2_read_idle", int'(cap[1]), 0);
        chk("rf_hits_after", int'(hit_count), 0);

        // randomized traffic with drops and stray l2_resp
        spurious_en = 1'b1;
        l2_lat = $urandom_range(1, 4);
        req_on = 1'b0; rdv = 1'b0; wrv = 1'b0; rs = 3'd0; rt = 4'd0;
        waited = 0;
        for (int n = 0; n < 2500; n++) begin
            if (!req_on && ph.size() == 0 && $urandom_range(0, 2) != 0) begin
                rs = 3'($urandom_range(0, 7));
                rt = 4'($urandom_range(0, 3));
                case ($urandom_range(0, 2))
                    0: begin rdv = 1'b1; wrv = 1'b0; end
                    1: begin rdv = 1'b0; wrv = 1'b1; end
                    default: begin rdv = 1'b1; wrv = 1'b1; end
                endcase
                req_on = 1'b1;
                waited = 0;
            end else if (req_on && ph.size() != 0 && $urandom_range(0, 15) == 0) begin
                req_on = 1'b0;
            end
            step(req_on ? rdv : 1'b0, req_on ? wrv : 1'b0, rs, rt);
            waited++;
            if (req_on && waited > 20) begin
                chk("req_timeout", waited, 0);
                req_on = 1'b0;
            end
            if (cap[17]) req_on = 1'b0;
        end

        // saturate the hit counter with back-to-back hits
        spurious_en = 1'b0;
        vld[0][0] = 1'b1; tg[0][0] = 4'd0; vld[1][0] = 1'b0;
        repeat (65540) step(1'b1, 1'b0, 3'd0, 4'd0);
        chk("sat_hits", int'(hit_count), 65535);
        repeat (3) step(1'b1, 1'b0, 3'd0, 4'd0);
        chk("sat_hits_hold", int'(hit_count), 65535);
        step(1'b0, 1'b0, 3'd0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
